// File: rtl/score_keeper.sv
// Two-player score register stage with match FSM, rise-edge point capture and saturation.
// Optional macro WIN_BY_TWO_EN: a win additionally needs a 2-point lead, with MAX_SCORE as the cap.
module score_keeper #(
  parameter int WIN_SCORE = 11,
  parameter int MAX_SCORE = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       p1_point,
  input  logic       p2_point,
  output logic [8:0] currscore,
  output logic [8:0] currscore2,
  output logic [1:0] state,
  output logic [1:0] winner,
  output logic       game_over
);

  localparam logic [8:0] LP_WIN = 9'(WIN_SCORE);
  localparam logic [8:0] LP_MAX = 9'(MAX_SCORE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_OVER = 2'b10,
    ST_BAD  = 2'b11
  } state_t;

  state_t     r_state, w_state_nx;
  logic [8:0] r_score1, r_score2, w_score1_nx, w_score2_nx;
  logic [8:0] w_inc1, w_inc2;
  logic [1:0] r_winner, w_winner_nx, w_result;
  logic       r_game_over, w_game_over_nx;
  logic       r_start_h, r_p1_h, r_p2_h;
  logic       w_start_rise, w_p1_rise, w_p2_rise;

  assign w_start_rise = start & ~r_start_h;
  assign w_p1_rise    = p1_point & ~r_p1_h;
  assign w_p2_rise    = p2_point & ~r_p2_h;

  // Candidate scores for this edge: one point per unpaused rise, held at the ceiling.
  always_comb begin
    w_inc1 = r_score1;
    w_inc2 = r_score2;
    if (w_p1_rise && !pause && (r_score1 < LP_MAX)) begin
      w_inc1 = r_score1 + 9'd1;
    end else begin
      w_inc1 = r_score1;
    end
    if (w_p2_rise && !pause && (r_score2 < LP_MAX)) begin
      w_inc2 = r_score2 + 9'd1;
    end else begin
      w_inc2 = r_score2;
    end
  end

  // Match result on the candidate scores; 00 means play continues.
`ifdef WIN_BY_TWO_EN
  always_comb begin
    w_result = 2'b00;
    if ((w_inc1 >= LP_WIN) && (w_inc1 >= w_inc2 + 9'd2)) begin
      w_result = 2'b01;
    end else if ((w_inc2 >= LP_WIN) && (w_inc2 >= w_inc1 + 9'd2)) begin
      w_result = 2'b10;
    end else if ((w_inc1 >= LP_MAX) || (w_inc2 >= LP_MAX)) begin
      if (w_inc1 > w_inc2) begin
        w_result = 2'b01;
      end else if (w_inc2 > w_inc1) begin
        w_result = 2'b10;
      end else begin
        w_result = 2'b11;
      end
    end else begin
      w_result = 2'b00;
    end
  end
`else
  always_comb begin
    w_result = {(w_inc2 >= LP_WIN), (w_inc1 >= LP_WIN)};
  end
`endif

  // Next-state and next-output decode for the match FSM.
  always_comb begin
    w_state_nx     = r_state;
    w_score1_nx    = r_score1;
    w_score2_nx    = r_score2;
    w_winner_nx    = r_winner;
    w_game_over_nx = r_game_over;
    case (r_state)
      ST_IDLE: begin
        w_score1_nx    = 9'd0;
        w_score2_nx    = 9'd0;
        w_winner_nx    = 2'b00;
        w_game_over_nx = 1'b0;
        if (w_start_rise) begin
          w_state_nx = ST_PLAY;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_PLAY: begin
        w_score1_nx = w_inc1;
        w_score2_nx = w_inc2;
        if (w_result != 2'b00) begin
          w_state_nx     = ST_OVER;
          w_winner_nx    = w_result;
          w_game_over_nx = 1'b1;
        end else begin
          w_state_nx     = ST_PLAY;
          w_winner_nx    = 2'b00;
          w_game_over_nx = 1'b0;
        end
      end
      ST_OVER: begin
        if (w_start_rise) begin
          w_state_nx     = ST_PLAY;
          w_score1_nx    = 9'd0;
          w_score2_nx    = 9'd0;
          w_winner_nx    = 2'b00;
          w_game_over_nx = 1'b0;
        end else begin
          w_state_nx     = ST_OVER;
          w_game_over_nx = 1'b1;
        end
      end
      default: begin
        w_state_nx     = ST_IDLE;
        w_score1_nx    = 9'd0;
        w_score2_nx    = 9'd0;
        w_winner_nx    = 2'b00;
        w_game_over_nx = 1'b0;
      end
    endcase
  end

  // State, score and edge-history registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_score1    <= 9'd0;
      r_score2    <= 9'd0;
      r_winner    <= 2'b00;
      r_game_over <= 1'b0;
      r_start_h   <= 1'b0;
      r_p1_h      <= 1'b0;
      r_p2_h      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_score1    <= w_score1_nx;
      r_score2    <= w_score2_nx;
      r_winner    <= w_winner_nx;
      r_game_over <= w_game_over_nx;
      r_start_h   <= start;
      r_p1_h      <= p1_point;
      r_p2_h      <= p2_point;
    end
  end

  assign currscore  = r_score1;
  assign currscore2 = r_score2;
  assign state      = r_state;
  assign winner     = r_winner;
  assign game_over  = r_game_over;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: directed vectors push expected snapshots, a monitor compares after each edge.
module tb_score_keeper;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] PLAY = 2'b01;
  localparam logic [1:0] OVER = 2'b10;

  typedef struct packed {
    logic [8:0] s1;
    logic [8:0] s2;
    logic [1:0] st;
    logic [1:0] w;
    logic       go;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       p1_point = 1'b0;
  logic       p2_point = 1'b0;
  logic [8:0] currscore, currscore2;
  logic [1:0] state, winner;
  logic       game_over;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   step = 0;

  score_keeper #(.WIN_SCORE(11), .MAX_SCORE(99)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause),
    .p1_point(p1_point), .p2_point(p2_point),
    .currscore(currscore), .currscore2(currscore2),
    .state(state), .winner(winner), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Monitor: one expected snapshot per posedge that had stimulus queued before it.
  always @(posedge clk) begin
    exp_t e, a;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      a = {currscore, currscore2, state, winner, game_over};
      total = total + 1;
      step  = step + 1;
      if (a !== e) begin
        bad = bad + 1;
        $display("FAIL step%0d: got s1=%0d s2=%0d st=%b w=%b go=%b, want s1=%0d s2=%0d st=%b w=%b go=%b",
                 step, a.s1, a.s2, a.st, a.w, a.go, e.s1, e.s2, e.st, e.w, e.go);
      end
    end
  end

  task automatic cyc(input logic rn, input logic st, input logic pa, input logic a, input logic b,
                     input int e1, input int e2, input logic [1:0] es, input logic [1:0] ew);
    exp_t e;
    @(negedge clk);
    rst_n = rn; start = st; pause = pa; p1_point = a; p2_point = b;
    e.s1 = 9'(e1);
    e.s2 = 9'(e2);
    e.st = es;
    e.w  = ew;
    e.go = (es == OVER);
    q.push_back(e);
  endtask

  task automatic pulse(input logic a, input logic b, input int e1, input int e2,
                       input logic [1:0] es, input logic [1:0] ew);
    cyc(1'b1, 1'b0, 1'b0, a, b, e1, e2, es, ew);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e1, e2, es, ew);
  endtask

  task automatic new_match();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, PLAY, 2'b00);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, PLAY, 2'b00);
  endtask

  initial begin
    // Reset, then start a match and score three p1 points.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, IDLE, 2'b00);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, IDLE, 2'b00);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, IDLE, 2'b00);
    new_match();
    for (int i = 1; i <= 3; i++) pulse(1'b1, 1'b0, i, 0, PLAY, 2'b00);

    // Held p2 scores once; then build 4/4 and score both on one edge.
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1, PLAY, 2'b00);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1, PLAY, 2'b00);
    pulse(1'b1, 1'b0, 4, 1, PLAY, 2'b00);
    for (int i = 2; i <= 4; i++) pulse(1'b0, 1'b1, 4, i, PLAY, 2'b00);
    pulse(1'b1, 1'b1, 5, 5, PLAY, 2'b00);

    // Pause swallows rises; releasing pause with p1 held does not score.
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5, 5, PLAY, 2'b00);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5, 5, PLAY, 2'b00);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5, 5, PLAY, 2'b00);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5, 5, PLAY, 2'b00);
    cyc(1'b1, 1'b0, 1'b0, 0, 1'b0, 5, 5, PLAY, 2'b00);
    pulse(1'b1, 1'b0, 6, 5, PLAY, 2'b00);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6, 5, PLAY, 2'b00);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6, 5, PLAY, 2'b00);

    // Mid-match reset wins over a simultaneous point; points in IDLE are ignored.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, IDLE, 2'b00);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, IDLE, 2'b00);
    pulse(1'b1, 1'b1, 0, 0, IDLE, 2'b00);

    // 10/7 then p1 reaches 11 and wins; later points ignored; restart clears.
    new_match();
    for (int i = 1; i <= 7; i++) pulse(1'b0, 1'b1, 0, i, PLAY, 2'b00);
    for (int i = 1; i <= 10; i++) pulse(1'b1, 1'b0, i, 7, PLAY, 2'b00);
    pulse(1'b1, 1'b0, 11, 7, OVER, 2'b01);
    pulse(1'b1, 1'b1, 11, 7, OVER, 2'b01);
    new_match();

    // Tie at 10/10, then the macro-dependent finish.
    for (int i = 1; i <= 10; i++) pulse(1'b1, 1'b1, i, i, PLAY, 2'b00);
`ifdef WIN_BY_TWO_EN
    pulse(1'b1, 1'b0, 11, 10, PLAY, 2'b00);
    pulse(1'b1, 1'b0, 12, 10, OVER, 2'b01);
    pulse(1'b0, 1'b1, 12, 10, OVER, 2'b01);
    new_match();
    for (int i = 1; i <= 98; i++) pulse(1'b1, 1'b1, i, i, PLAY, 2'b00);
    pulse(1'b1, 1'b0, 99, 98, OVER, 2'b01);
    pulse(1'b1, 1'b1, 99, 98, OVER, 2'b01);
    new_match();
`else
    pulse(1'b1, 1'b1, 11, 11, OVER, 2'b11);
    pulse(1'b0, 1'b1, 11, 11, OVER, 2'b11);
    new_match();
    pulse(1'b0, 1'b1, 0, 1, PLAY, 2'b00);
`endif

    @(negedge clk);
    @(negedge clk);
    total = total + 1;
    if (q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
